// File: rtl/ahb_pkg.sv
// AHB shared definitions: bus widths, HRESP/HTRANS encodings and the
// state type of the slave-to-master response multiplexer.
package ahb_pkg;

  localparam int AHB_DATA_BITS = 32;
  localparam int AHB_RESP_BITS = 2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ROUTE = 2'd0,
    ERR1  = 2'd1,
    ERR2  = 2'd2
  } s2m_state_e;

endpackage

// File: rtl/ahb_stall_wdog.sv
// Per-transfer stall watchdog for the S2M mux.
//   clk, rst         : bus clock, async active-high reset
//   stall            : routed slave is active and holding HREADY_S low
//   ready            : HREADY seen by the master (clears the count)
//   clr              : mux is in an error state (clears the count)
//   slave_idx        : index of the currently routed slave
//   abort            : combinational, this stall cycle is the last allowed
//   timeout_err      : one-cycle pulse in the cycle following an abort
//   timeout_slave    : index of the last aborted slave, held until next abort
// With TIMEOUT=0 the whole block collapses to constants.
module ahb_stall_wdog #(
  parameter int TIMEOUT = 16,
  parameter int IDX_W   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ready,
  input  logic             clr,
  input  logic [IDX_W-1:0] slave_idx,
  output logic             abort,
  output logic             timeout_err,
  output logic [IDX_W-1:0] timeout_slave
);

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] cnt;

      // A ready slave never counts as stalled, so the slave wins a tie
      // with the terminal count.
      assign abort = stall && (cnt == CNT_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (ready || clr || abort) begin
          cnt <= '0;
        end else if (stall) begin
          cnt <= cnt + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          timeout_err   <= 1'b0;
          timeout_slave <= '0;
        end else begin
          timeout_err <= abort;
          if (abort) begin
            timeout_slave <= slave_idx;
          end
        end
      end
    end else begin : g_no_wdog
      logic unused_wdog;
      assign unused_wdog   = &{1'b0, clk, rst, stall, ready, clr, slave_idx};
      assign abort         = 1'b0;
      assign timeout_err   = 1'b0;
      assign timeout_slave = '0;
    end
  endgenerate

endmodule

// File: rtl/ahb_mux_s2m_n.sv
// AHB slave-to-master response multiplexer for NUM_SLAVES slaves.
// Registers the address-phase slave select and routes the selected slave's
// HRDATA/HREADY/HRESP to the master in the data phase. An embedded default
// slave answers unmapped active transfers with a two-cycle ERROR, and a stall
// watchdog aborts a hung slave with an ERROR response.
//   HCLK, HRESET   : bus clock, async active-high reset
//   HSEL           : address-phase one-hot select (bit i = slave i)
//   HSELDefault    : address-phase default select (routing uses HSEL only)
//   HTRANS         : address-phase transfer type
//   HRDATA_S/HREADY_S/HRESP_S : packed per-slave responses
//   HRDATA/HREADY/HRESP       : response to master (HREADY also to slaves)
//   timeout_err    : one-cycle pulse on a watchdog abort
//   timeout_slave  : index of the last aborted slave
module ahb_mux_s2m_n
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int DATA_W     = AHB_DATA_BITS,
  parameter int RESP_W     = AHB_RESP_BITS,
  parameter int TIMEOUT    = 16,
  parameter int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [NUM_SLAVES-1:0]        HSEL,
  input  logic                         HSELDefault,
  input  logic [1:0]                   HTRANS,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADY_S,
  input  logic [NUM_SLAVES*RESP_W-1:0] HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic [RESP_W-1:0]            HRESP,
  output logic                         timeout_err,
  output logic [IDX_W-1:0]             timeout_slave
);

  s2m_state_e state;

  logic [NUM_SLAVES-1:0] sel_q;
  logic                  act_q;

  logic [IDX_W-1:0]      idx;
  logic                  sel_onehot;
  logic [DATA_W-1:0]     slv_data;
  logic                  slv_ready;
  logic [RESP_W-1:0]     slv_resp;

  logic                  wd_stall;
  logic                  wd_abort;

  // The default slave is implied by a non-one-hot select; the explicit
  // default select and the BUSY/SEQ distinction carry no extra information.
  logic unused_in;
  assign unused_in = &{1'b0, HSELDefault, HTRANS[0]};

  always_comb begin
    int unsigned hits;
    hits      = 0;
    idx       = '0;
    slv_data  = '0;
    slv_ready = 1'b1;
    slv_resp  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        hits      = hits + 1;
        idx       = IDX_W'(i);
        slv_data  = HRDATA_S[i*DATA_W +: DATA_W];
        slv_ready = HREADY_S[i];
        slv_resp  = HRESP_S[i*RESP_W +: RESP_W];
      end
    end
    sel_onehot = (hits == 1);
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = RESP_W'(HRESP_OKAY);
    unique case (state)
      ROUTE: begin
        if (sel_onehot) begin
          HRDATA = slv_data;
          HREADY = slv_ready;
          HRESP  = slv_resp;
        end else if (act_q) begin
          HREADY = 1'b0;
          HRESP  = RESP_W'(HRESP_ERROR);
        end
      end
      ERR1: begin
        HREADY = 1'b0;
        HRESP  = RESP_W'(HRESP_ERROR);
      end
      ERR2: begin
        HREADY = 1'b1;
        HRESP  = RESP_W'(HRESP_ERROR);
      end
      default: begin
        HREADY = 1'b1;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q <= '0;
      act_q <= 1'b0;
    end else if (HREADY) begin
      sel_q <= HSEL;
      act_q <= HTRANS[1];
    end
  end

  // The default-slave error already spends its first cycle in ROUTE with
  // HREADY low, so it jumps straight to ERR2; ERR1 belongs to the watchdog.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ROUTE;
    end else begin
      unique case (state)
        ROUTE: begin
          if (!sel_onehot && act_q) begin
            state <= ERR2;
          end else if (wd_abort) begin
            state <= ERR1;
          end
        end
        ERR1:    state <= ERR2;
        ERR2:    state <= ROUTE;
        default: state <= ROUTE;
      endcase
    end
  end

  assign wd_stall = (state == ROUTE) && sel_onehot && act_q && !slv_ready;

  ahb_stall_wdog #(
    .TIMEOUT (TIMEOUT),
    .IDX_W   (IDX_W)
  ) u_wdog (
    .clk           (HCLK),
    .rst           (HRESET),
    .stall         (wd_stall),
    .ready         (HREADY),
    .clr           (state != ROUTE),
    .slave_idx     (idx),
    .abort         (wd_abort),
    .timeout_err   (timeout_err),
    .timeout_slave (timeout_slave)
  );

endmodule

// File: tb/tb_ahb_mux_s2m_n.sv
// Bench for ahb_mux_s2m_n: instance a has TIMEOUT=16, instance b TIMEOUT=0,
// both with four slaves and sharing all inputs. Per-cycle expectations are
// queued when inputs are driven and compared on the falling edge.
module tb_ahb_mux_s2m_n;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int RW = 2;

  logic            HCLK;
  logic            HRESET;
  logic [NS-1:0]   HSEL;
  logic            HSELDefault;
  logic [1:0]      HTRANS;
  logic [NS*DW-1:0] HRDATA_S;
  logic [NS-1:0]   HREADY_S;
  logic [NS*RW-1:0] HRESP_S;

  logic [DW-1:0] hrdata_a, hrdata_b;
  logic          hready_a, hready_b;
  logic [RW-1:0] hresp_a, hresp_b;
  logic          terr_a, terr_b;
  logic [1:0]    tslv_a, tslv_b;

  ahb_mux_s2m_n #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .RESP_W     (RW),
    .TIMEOUT    (16)
  ) dut_a (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .HSEL          (HSEL),
    .HSELDefault   (HSELDefault),
    .HTRANS        (HTRANS),
    .HRDATA_S      (HRDATA_S),
    .HREADY_S      (HREADY_S),
    .HRESP_S       (HRESP_S),
    .HRDATA        (hrdata_a),
    .HREADY        (hready_a),
    .HRESP         (hresp_a),
    .timeout_err   (terr_a),
    .timeout_slave (tslv_a)
  );

  ahb_mux_s2m_n #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .RESP_W     (RW),
    .TIMEOUT    (0)
  ) dut_b (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .HSEL          (HSEL),
    .HSELDefault   (HSELDefault),
    .HTRANS        (HTRANS),
    .HRDATA_S      (HRDATA_S),
    .HREADY_S      (HREADY_S),
    .HRESP_S       (HRESP_S),
    .HRDATA        (hrdata_b),
    .HREADY        (hready_b),
    .HRESP         (hresp_b),
    .timeout_err   (terr_b),
    .timeout_slave (tslv_b)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    string       tag;
    bit          chk_a;
    bit          chk_b;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] data;
    logic        terr;
    logic [1:0]  tslv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge HCLK) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.chk_a) begin
        check({e.tag, ".a.rdy"},  32'(hready_a), 32'(e.rdy));
        check({e.tag, ".a.resp"}, 32'(hresp_a),  32'(e.resp));
        check({e.tag, ".a.data"}, hrdata_a,      e.data);
        check({e.tag, ".a.terr"}, 32'(terr_a),   32'(e.terr));
        check({e.tag, ".a.tslv"}, 32'(tslv_a),   32'(e.tslv));
      end
      if (e.chk_b) begin
        check({e.tag, ".b.rdy"},  32'(hready_b), 32'(e.rdy));
        check({e.tag, ".b.resp"}, 32'(hresp_b),  32'(e.resp));
        check({e.tag, ".b.data"}, hrdata_b,      e.data);
        check({e.tag, ".b.terr"}, 32'(terr_b),   32'(e.terr));
        check({e.tag, ".b.tslv"}, 32'(tslv_b),   32'(e.tslv));
      end
    end
  end

  // Queue the expected outputs for the cycle whose inputs are now applied,
  // then move to just after the next rising edge.
  task automatic expect_out(input string tag, input bit a, input bit b,
                            input logic rdy, input logic [1:0] resp,
                            input logic [31:0] data, input logic terr,
                            input logic [1:0] tslv);
    exp_t e;
    e.tag = tag; e.chk_a = a; e.chk_b = b;
    e.rdy = rdy; e.resp = resp; e.data = data; e.terr = terr; e.tslv = tslv;
    sb.push_back(e);
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [31:0] sdata(input int i);
    return 32'hA0A0_0000 | 32'(i);
  endfunction

  task automatic set_idle();
    HSEL        = '0;
    HSELDefault = 1'b0;
    HTRANS      = 2'b00;
    HREADY_S    = '1;
    HRESP_S     = '0;
    for (int i = 0; i < NS; i++) HRDATA_S[i*DW +: DW] = sdata(i);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    set_idle();
    expect_out("rst", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HRESET = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1;
    set_idle();
    #2;
    @(posedge HCLK);
    #1;
    expect_out("reset", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HRESET = 1'b0;
    expect_out("post_reset", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);

    // Read slave 2 with three wait states.
    HRDATA_S[2*DW +: DW] = 32'hDEADBEEF;
    HSEL = 4'b0100; HTRANS = 2'b10;
    expect_out("rd2.addr", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HSEL = '0; HTRANS = 2'b00; HREADY_S[2] = 1'b0;
    for (int i = 0; i < 3; i++)
      expect_out("rd2.wait", 1, 1, 1'b0, 2'b00, 32'hDEADBEEF, 1'b0, 2'd0);
    HREADY_S[2] = 1'b1;
    expect_out("rd2.done", 1, 1, 1'b1, 2'b00, 32'hDEADBEEF, 1'b0, 2'd0);
    expect_out("rd2.idle", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);

    // Unmapped NONSEQ: two-cycle default ERROR, then IDLE gives OKAY.
    HSEL = '0; HSELDefault = 1'b1; HTRANS = 2'b10;
    expect_out("dflt.addr", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HSELDefault = 1'b0; HTRANS = 2'b00;
    expect_out("dflt.e1", 1, 1, 1'b0, 2'b01, 32'h0, 1'b0, 2'd0);
    expect_out("dflt.e2", 1, 1, 1'b1, 2'b01, 32'h0, 1'b0, 2'd0);
    expect_out("dflt.idle", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);

    // Two-hot select with SEQ: default ERROR, no slave data leaks through.
    HSEL = 4'b0110; HTRANS = 2'b11;
    expect_out("hot2.addr", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HSEL = '0; HTRANS = 2'b00;
    expect_out("hot2.e1", 1, 1, 1'b0, 2'b01, 32'h0, 1'b0, 2'd0);
    expect_out("hot2.e2", 1, 1, 1'b1, 2'b01, 32'h0, 1'b0, 2'd0);
    expect_out("hot2.idle", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);

    // Slave 3 issues its own two-cycle ERROR, passed through unchanged.
    HSEL = 4'b1000; HTRANS = 2'b10;
    expect_out("s3err.addr", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HSEL = '0; HTRANS = 2'b00; HREADY_S[3] = 1'b0; HRESP_S[3*RW +: RW] = 2'b01;
    expect_out("s3err.c1", 1, 1, 1'b0, 2'b01, sdata(3), 1'b0, 2'd0);
    HREADY_S[3] = 1'b1;
    expect_out("s3err.c2", 1, 1, 1'b1, 2'b01, sdata(3), 1'b0, 2'd0);
    HRESP_S[3*RW +: RW] = 2'b00;
    expect_out("s3err.idle", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);

    // Slave 1 hangs: 16 stall cycles, then ERR1 with pulse, ERR2, ROUTE.
    do_reset();
    HSEL = 4'b0010; HTRANS = 2'b10;
    expect_out("wd.addr", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HSEL = '0; HTRANS = 2'b00; HREADY_S[1] = 1'b0;
    for (int i = 0; i < 16; i++)
      expect_out("wd.stall", 1, 1, 1'b0, 2'b00, sdata(1), 1'b0, 2'd0);
    expect_out("wd.err1", 1, 0, 1'b0, 2'b01, 32'h0, 1'b1, 2'd1);
    expect_out("wd.err2", 1, 0, 1'b1, 2'b01, 32'h0, 1'b0, 2'd1);
    expect_out("wd.idle", 1, 0, 1'b1, 2'b00, 32'h0, 1'b0, 2'd1);

    // Slave 0 stalls 15 cycles and is ready on the 16th: no abort.
    do_reset();
    HSEL = 4'b0001; HTRANS = 2'b10;
    expect_out("win.addr", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HSEL = '0; HTRANS = 2'b00; HREADY_S[0] = 1'b0;
    for (int i = 0; i < 15; i++)
      expect_out("win.stall", 1, 1, 1'b0, 2'b00, sdata(0), 1'b0, 2'd0);
    HREADY_S[0] = 1'b1;
    expect_out("win.done", 1, 1, 1'b1, 2'b00, sdata(0), 1'b0, 2'd0);
    expect_out("win.idle", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);

    // TIMEOUT=0 instance tolerates a 100-cycle stall.
    do_reset();
    HSEL = 4'b0001; HTRANS = 2'b10;
    expect_out("nowd.addr", 0, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HSEL = '0; HTRANS = 2'b00; HREADY_S[0] = 1'b0;
    for (int i = 0; i < 100; i++)
      expect_out("nowd.stall", 0, 1, 1'b0, 2'b00, sdata(0), 1'b0, 2'd0);
    HREADY_S[0] = 1'b1;
    expect_out("nowd.done", 0, 1, 1'b1, 2'b00, sdata(0), 1'b0, 2'd0);
    expect_out("nowd.idle", 0, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);

    // Reset asserted while instance a sits in ERR1.
    do_reset();
    HSEL = 4'b0010; HTRANS = 2'b10;
    expect_out("rerr.addr", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HSEL = '0; HTRANS = 2'b00; HREADY_S[1] = 1'b0;
    for (int i = 0; i < 16; i++)
      expect_out("rerr.stall", 1, 1, 1'b0, 2'b00, sdata(1), 1'b0, 2'd0);
    HRESET = 1'b1;
    HREADY_S = '1;
    expect_out("rerr.in_rst", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    HRESET = 1'b0;
    expect_out("rerr.after", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);
    expect_out("rerr.after2", 1, 1, 1'b1, 2'b00, 32'h0, 1'b0, 2'd0);

    check("sb.drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
